// File: rtl/seven_segment_mux.sv
// rtl/seven_segment_mux.sv - multiplexed seven-segment driver with frame-aligned commit and 16-level PWM
// Optional leading-zero suppression: SEVEN_SEGMENT_LEADING_ZERO_EN
module seven_segment_mux #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int REFRESH_RATE  = 200,
  parameter int NUM_DIGITS    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  input  logic                    blank,
  input  logic [3:0]              brightness,
  output logic [7:0]              segment,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    update_pending,
  output logic                    frame_start
);

  localparam int DIGIT_CYCLES = CLK_FREQUENCY / (REFRESH_RATE * NUM_DIGITS);
  localparam int SLOT_CYCLES  = DIGIT_CYCLES / 16;
  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
      $error("seven_segment_mux: NUM_DIGITS must be 1..16");
    end
    if (DIGIT_CYCLES < 16 || (DIGIT_CYCLES % 16) != 0) begin : g_bad_cycles
      $error("seven_segment_mux: DIGIT_CYCLES must be a non-zero multiple of 16");
    end
  endgenerate

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DW-1:0]           digit_q, digit_d;
  logic                    cnt_wrap, boundary;
  logic [4*NUM_DIGITS-1:0] shadow_data_q, active_data_q, commit_data;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, active_dp_q, commit_dp;
  logic [NUM_DIGITS-1:0]   shadow_en_q, active_en_q, commit_en_raw, commit_en;
  logic                    pending_q, pending_d;
  logic [7:0]              segment_q, segment_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic                    frame_start_q, frame_start_d;
  logic [3:0]              nibble, slot;
  logic                    cur_en, cur_dp;

  always_comb begin
    cnt_wrap = (cnt_q == CW'(DIGIT_CYCLES - 1));
    boundary = cnt_wrap && (digit_q == DW'(NUM_DIGITS - 1));
    cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
    digit_d  = digit_q;
    if (cnt_wrap) begin
      digit_d = boundary ? '0 : digit_q + 1'b1;
    end
    pending_d = boundary ? 1'b0 : (load ? 1'b1 : pending_q);
  end

  // A load on the boundary cycle goes straight to active instead of waiting a frame.
  always_comb begin
    commit_data   = load ? data_in  : shadow_data_q;
    commit_dp     = load ? dp_in    : shadow_dp_q;
    commit_en_raw = load ? digit_en : shadow_en_q;
  end

`ifdef SEVEN_SEGMENT_LEADING_ZERO_EN
  logic upper_zero;
  always_comb begin
    commit_en  = commit_en_raw;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (commit_data[4*i +: 4] == 4'h0);
      if (upper_zero && !commit_dp[i] && (i != 0)) begin
        commit_en[i] = 1'b0;
      end
    end
  end
`else
  assign commit_en = commit_en_raw;
`endif

  always_comb begin
    nibble        = active_data_q[{digit_q, 2'b00} +: 4];
    cur_en        = active_en_q[digit_q];
    cur_dp        = active_dp_q[digit_q];
    slot          = 4'(cnt_q / SLOT_CYCLES);
    // Disabled digits also release their segments so the pins idle high.
    segment_d     = cur_en ? {~cur_dp, ~hex7(nibble)} : 8'hFF;
    anode_d       = '1;
    if (cur_en && !blank && (slot <= brightness)) begin
      anode_d[digit_q] = 1'b0;
    end
    frame_start_d = (cnt_q == '0) && (digit_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      digit_q       <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      shadow_en_q   <= '0;
      active_data_q <= '0;
      active_dp_q   <= '0;
      active_en_q   <= '0;
      pending_q     <= 1'b0;
      segment_q     <= 8'hFF;
      anode_q       <= '1;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      digit_q       <= digit_d;
      pending_q     <= pending_d;
      segment_q     <= segment_d;
      anode_q       <= anode_d;
      frame_start_q <= frame_start_d;
      if (load) begin
        shadow_data_q <= data_in;
        shadow_dp_q   <= dp_in;
        shadow_en_q   <= digit_en;
      end
      if (boundary && (load || pending_q)) begin
        active_data_q <= commit_data;
        active_dp_q   <= commit_dp;
        active_en_q   <= commit_en;
      end
    end
  end

  assign segment        = segment_q;
  assign anode          = anode_q;
  assign update_pending = pending_q;
  assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// tb/tb_seven_segment_mux.sv - scoreboard bench for seven_segment_mux (4 digits, 16 cycles per digit)
module tb_seven_segment_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic [3:0]  dp_in, digit_en, brightness, anode;
  logic        load, blank, update_pending, frame_start;
  logic [7:0]  segment;

  always #5 clk = ~clk;

  seven_segment_mux #(.CLK_FREQUENCY(1600), .REFRESH_RATE(25), .NUM_DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .digit_en(digit_en),
    .load(load), .blank(blank), .brightness(brightness), .segment(segment),
    .anode(anode), .update_pending(update_pending), .frame_start(frame_start)
  );

  typedef struct packed {
    logic [31:0] seg;
    logic [3:0]  lit;
    logic [3:0]  bright;
  } frame_t;

  frame_t exp_q[$];
  int     checks = 0;
  int     failures = 0;
  logic   mon_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: each expected frame is checked cycle by cycle from the frame_start it belongs to.
  initial begin : monitor
    frame_t     r;
    logic [3:0] ea;
    forever begin
      @(negedge clk);
      if (frame_start === 1'b1 && exp_q.size() > 0) begin
        mon_busy = 1'b1;
        r = exp_q.pop_front();
        for (int d = 0; d < 4; d++) begin
          for (int c = 0; c < 16; c++) begin
            if (d != 0 || c != 0) @(negedge clk);
            ea = 4'hF;
            if (r.lit[d] && c <= int'(r.bright)) ea[d] = 1'b0;
            check($sformatf("frame_anode d%0d c%0d", d, c), anode, ea);
            if (r.lit[d]) check($sformatf("frame_segment d%0d c%0d", d, c), segment, r.seg[8*d +: 8]);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("scoreboard_drain_timeout", n < 400, 1);
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 200);
    check("frame_start_seen", frame_start, 1);
  endtask

  task automatic check_dark(input string name, input int cycles);
    int bad = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (segment !== 8'hFF || anode !== 4'hF || update_pending !== 1'b0) bad++;
    end
    check(name, bad, 0);
  endtask

  task automatic load_mid(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en,
                          input frame_t rec);
    wait_fs();
    repeat (5) @(posedge clk);
    #1;
    data_in = d; dp_in = dp; digit_en = en; load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    check("pending_after_load", update_pending, 1);
    exp_q.push_back(rec);
    wait_idle();
    check("pending_after_commit", update_pending, 0);
  endtask

  logic [3:0] ea;
  int         bad;

  initial begin
    rst_n = 1'b0; data_in = '0; dp_in = '0; digit_en = '0;
    load = 1'b0; blank = 1'b0; brightness = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("reset_segment", segment, 8'hFF);
    check("reset_anode", anode, 4'hF);
    check("reset_pending", update_pending, 0);
    check("reset_frame_start", frame_start, 0);
    rst_n = 1'b1;
    check_dark("dark_after_reset", 128);

    wait_fs();
    repeat (10) @(posedge clk);
    #1;
    data_in = 16'h1F80; dp_in = 4'b0100; digit_en = 4'hF; load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    check("pending_after_load_1f80", update_pending, 1);
    exp_q.push_back('{seg: 32'hF90E80C0, lit: 4'hF, bright: 4'hF});
    wait_idle();
    check("pending_cleared_1f80", update_pending, 0);

    // Two loads in one frame: old content stays until the boundary, last load wins.
    wait_fs();
    repeat (5) @(posedge clk);
    #1;
    data_in = 16'h2222; dp_in = 4'b0000; load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    check("pending_first_load", update_pending, 1);
    check("old_digit0_kept", segment, 8'hC0);
    repeat (10) @(posedge clk);
    #1;
    data_in = 16'h3333; load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    check("pending_second_load", update_pending, 1);
    check("old_digit1_kept", segment, 8'h80);
    exp_q.push_back('{seg: 32'hB0B0B0B0, lit: 4'hF, bright: 4'hF});
    wait_idle();
    check("pending_cleared_3333", update_pending, 0);

    brightness = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('{seg: 32'hB0B0B0B0, lit: 4'hF, bright: 4'd3});
    wait_idle();

    // blank high for 5 sampled cycles -> outputs 15..19 dark, phase unchanged.
    wait_fs();
    bad = 0;
    for (int j = 1; j <= 65; j++) begin
      if (j > 1) @(negedge clk);
      ea = 4'hF;
      if (!(j >= 15 && j <= 19) && ((j - 1) % 16) <= 3) ea[((j - 1) / 16) % 4] = 1'b0;
      if (anode !== ea) begin
        bad++;
        $display("FAIL blank_anode j=%0d actual=%h required=%h", j, anode, ea);
      end
      if (j == 65) check("blank_phase_frame_start", frame_start, 1);
      if (j == 14) blank = 1'b1;
      if (j == 19) blank = 1'b0;
    end
    check("blank_window", bad, 0);

    brightness = 4'hF;
    wait_fs();
    repeat (62) @(posedge clk);
    #1;
    data_in = 16'h4D6E; dp_in = 4'b0001; digit_en = 4'b1011; load = 1'b1;
    exp_q.push_back('{seg: 32'h99FF8206, lit: 4'b1011, bright: 4'hF});
    @(posedge clk);
    #1;
    load = 1'b0;
    check("bypass_pending_0", update_pending, 0);
    @(posedge clk);
    #1;
    check("bypass_pending_1", update_pending, 0);
    wait_idle();
    check("bypass_pending_end", update_pending, 0);

    wait_fs();
    repeat (5) @(posedge clk);
    #1;
    data_in = 16'h8888; dp_in = 4'b0000; digit_en = 4'hF; load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    check("pending_before_reset", update_pending, 1);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_segment", segment, 8'hFF);
    check("async_reset_anode", anode, 4'hF);
    check("async_reset_pending", update_pending, 0);
    check("async_reset_frame_start", frame_start, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_dark("dark_after_mid_reset", 140);

`ifdef SEVEN_SEGMENT_LEADING_ZERO_EN
    load_mid(16'h0050, 4'b0000, 4'hF, '{seg: 32'hC0C092C0, lit: 4'b0011, bright: 4'hF});
    load_mid(16'h0000, 4'b0000, 4'hF, '{seg: 32'hC0C0C0C0, lit: 4'b0001, bright: 4'hF});
    load_mid(16'h0050, 4'b0100, 4'hF, '{seg: 32'hC04092C0, lit: 4'b0111, bright: 4'hF});
`else
    load_mid(16'h0050, 4'b0000, 4'hF, '{seg: 32'hC0C092C0, lit: 4'hF, bright: 4'hF});
    load_mid(16'h0000, 4'b0000, 4'hF, '{seg: 32'hC0C0C0C0, lit: 4'hF, bright: 4'hF});
    load_mid(16'h0050, 4'b0100, 4'hF, '{seg: 32'hC04092C0, lit: 4'hF, bright: 4'hF});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
